// File: rtl/spi_flash_read_seq.sv
// APB master that turns a (flash byte address, word count) request into SPI flash READ (0x03) bursts
// and streams the returned words. Define SPI_SEQ_TIMEOUT_EN to add the end-of-transfer watchdog.
`timescale 1ns/1ps
module spi_flash_read_seq #(
  parameter int APB_ADDR_WIDTH = 12,
  parameter int MAX_BURST      = 8,
  parameter int TIMEOUT_CYCLES = 65535
) (
  input  logic                      HCLK,
  input  logic                      HRESET,
  input  logic                      req_valid_i,
  output logic                      req_ready_o,
  input  logic [23:0]               req_addr_i,
  input  logic [15:0]               req_words_i,
  output logic [APB_ADDR_WIDTH-1:0] PADDR,
  output logic [31:0]               PWDATA,
  output logic                      PWRITE,
  output logic                      PSEL,
  output logic                      PENABLE,
  input  logic [31:0]               PRDATA,
  input  logic                      PREADY,
  input  logic                      PSLVERR,
  input  logic                      eot_i,
  output logic [31:0]               data_o,
  output logic                      data_valid_o,
  input  logic                      data_ready_i,
  output logic                      done_o,
  output logic                      err_o
);

  localparam logic [APB_ADDR_WIDTH-1:0] A_STATUS = APB_ADDR_WIDTH'(8'h00);
  localparam logic [APB_ADDR_WIDTH-1:0] A_CMD    = APB_ADDR_WIDTH'(8'h08);
  localparam logic [APB_ADDR_WIDTH-1:0] A_ADDR   = APB_ADDR_WIDTH'(8'h0C);
  localparam logic [APB_ADDR_WIDTH-1:0] A_LEN    = APB_ADDR_WIDTH'(8'h10);
  localparam logic [APB_ADDR_WIDTH-1:0] A_RXFIFO = APB_ADDR_WIDTH'(8'h20);
  localparam logic [15:0]               BURST_MAX = 16'(MAX_BURST);

  typedef enum logic [3:0] {
    S_IDLE, S_CMD, S_ADDR, S_LEN, S_CTRL, S_WAIT, S_RD, S_PUSH, S_DONE, S_SWRST
  } state_t;

  // GAP keeps PSEL low for one cycle between consecutive register writes.
  typedef enum logic [1:0] {PH_GAP, PH_SETUP, PH_ACCESS} phase_t;

  state_t      state, state_n;
  phase_t      phase, phase_n;
  logic [23:0] addr;
  logic [15:0] remain;
  logic [15:0] burst_left;
  logic [15:0] burst_n;
  logic [15:0] len_bits;
  logic [31:0] data;
  logic        valid;
  logic        err;
  logic        apb_req;
  logic        eot_setup;
  logic        xfer_done;
  logic        tmo_hit;

`ifdef SPI_SEQ_TIMEOUT_EN
  localparam logic [15:0] TMO_LIMIT = 16'(TIMEOUT_CYCLES);
  logic [15:0] tmo_cnt;

  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) tmo_cnt <= '0;
    else if (state == S_WAIT) tmo_cnt <= tmo_cnt + 16'd1;
    else tmo_cnt <= '0;
  end

  assign tmo_hit = (tmo_cnt == TMO_LIMIT);
`else
  assign tmo_hit = 1'b0;
`endif

  assign burst_n      = (remain > BURST_MAX) ? BURST_MAX : remain;
  assign len_bits     = burst_n << 5;
  // The RXFIFO read SETUP overlaps the eot cycle so the first word lands two cycles after eot.
  assign eot_setup    = (state == S_WAIT) && eot_i;
  assign xfer_done    = PENABLE && PREADY;
  assign req_ready_o  = (state == S_IDLE);
  assign done_o       = (state == S_DONE);
  assign data_o       = data;
  assign data_valid_o = valid;
  assign err_o        = err;

  always_comb begin
    apb_req = 1'b0;
    PADDR   = '0;
    PWDATA  = '0;
    PWRITE  = 1'b0;
    case (state)
      S_CMD:   begin apb_req = 1'b1; PADDR = A_CMD;    PWDATA = 32'h0300_0000;  PWRITE = 1'b1; end
      S_ADDR:  begin apb_req = 1'b1; PADDR = A_ADDR;   PWDATA = {addr, 8'h00};  PWRITE = 1'b1; end
      S_LEN:   begin
        apb_req = 1'b1;
        PADDR   = A_LEN;
        PWDATA  = {len_bits, 2'b00, 6'd24, 2'b00, 6'd8};
        PWRITE  = 1'b1;
      end
      S_CTRL:  begin apb_req = 1'b1; PADDR = A_STATUS; PWDATA = 32'h0000_0101;  PWRITE = 1'b1; end
      S_SWRST: begin apb_req = 1'b1; PADDR = A_STATUS; PWDATA = 32'h0000_0010;  PWRITE = 1'b1; end
      S_RD:    begin apb_req = 1'b1; PADDR = A_RXFIFO; end
      S_WAIT:  if (eot_i) PADDR = A_RXFIFO;
      default: ;
    endcase
    PSEL    = (apb_req && (phase != PH_GAP)) || eot_setup;
    PENABLE = apb_req && (phase == PH_ACCESS);
  end

  always_comb begin
    state_n = state;
    phase_n = phase;
    case (state)
      S_IDLE:
        if (req_valid_i) begin
          phase_n = PH_SETUP;
          state_n = (req_words_i == 16'd0) ? S_DONE : S_CMD;
        end
      S_CMD, S_ADDR, S_LEN, S_CTRL, S_RD, S_SWRST:
        if (phase == PH_GAP) phase_n = PH_SETUP;
        else if (phase == PH_SETUP) phase_n = PH_ACCESS;
        else if (PREADY) begin
          phase_n = PH_GAP;
          if (PSLVERR) state_n = S_DONE;
          else begin
            case (state)
              S_CMD:   state_n = S_ADDR;
              S_ADDR:  state_n = S_LEN;
              S_LEN:   state_n = S_CTRL;
              S_CTRL:  state_n = S_WAIT;
              S_RD:    state_n = S_PUSH;
              default: state_n = S_DONE;
            endcase
          end
        end
      S_WAIT:
        if (eot_i) begin
          state_n = S_RD;
          phase_n = PH_ACCESS;
        end else if (tmo_hit) begin
          state_n = S_SWRST;
          phase_n = PH_SETUP;
        end
      S_PUSH:
        if (data_ready_i) begin
          phase_n = PH_SETUP;
          if (burst_left == 16'd1) state_n = (remain == 16'd1) ? S_DONE : S_CMD;
          else state_n = S_RD;
        end
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      state      <= S_IDLE;
      phase      <= PH_GAP;
      addr       <= '0;
      remain     <= '0;
      burst_left <= '0;
      data       <= '0;
      valid      <= 1'b0;
      err        <= 1'b0;
    end else begin
      state <= state_n;
      phase <= phase_n;
      if (xfer_done && PSLVERR) err <= 1'b1;
      case (state)
        S_IDLE:
          if (req_valid_i) begin
            addr   <= req_addr_i & 24'hFF_FFFC;
            remain <= req_words_i;
            err    <= 1'b0;
          end
        S_CTRL:  if (xfer_done) burst_left <= burst_n;
        S_RD:
          if (xfer_done && !PSLVERR) begin
            data  <= PRDATA;
            valid <= 1'b1;
          end
        // Address and remaining count advance per delivered word; the wrap is modulo 2^24.
        S_PUSH:
          if (data_ready_i) begin
            valid      <= 1'b0;
            addr       <= addr + 24'd4;
            remain     <= remain - 16'd1;
            burst_left <= burst_left - 16'd1;
          end
        S_SWRST: if (xfer_done) err <= 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_flash_read_seq.sv
// Directed bench for spi_flash_read_seq: APB slave responder with EOT generator, stream and done monitors.
`timescale 1ns/1ps
module tb_spi_flash_read_seq;

  localparam logic [31:0] RD_BASE = 32'hC0DE_0000;

  logic        HCLK = 1'b0;
  logic        HRESET;
  logic        req_valid_i;
  logic        req_ready_o;
  logic [23:0] req_addr_i;
  logic [15:0] req_words_i;
  logic [11:0] PADDR;
  logic [31:0] PWDATA;
  logic        PWRITE, PSEL, PENABLE;
  logic [31:0] PRDATA;
  logic        PREADY, PSLVERR, eot_i;
  logic [31:0] data_o;
  logic        data_valid_o, data_ready_i, done_o, err_o;

  int checks = 0;
  int errors = 0;

  // bench-side knobs written only by the stimulus process
  bit          slow;
  int          eot_delay;
  int          err_req_n;
  logic [11:0] err_addr;

  // responder state
  int          eot_cd = 0;
  int          err_fired_n = 0;
  int          rd_count = 0;
  bit          pend_rd = 0;
  int          cyc = 0;
  int          psel_cnt = 0;
  int          done_cnt = 0;
  int          prot_err = 0;
  bit          prev_sel = 0, prev_done = 0, prev_write = 0;
  logic [11:0] prev_addr = '0;
  logic [31:0] prev_wdata = '0;
  int          log_n = 0;
  logic [11:0] lg_addr [0:511];
  logic [31:0] lg_data [0:511];
  bit          lg_wr   [0:511];
  int          lg_cyc  [0:511];
  logic [31:0] outq [$];

  spi_flash_read_seq #(.APB_ADDR_WIDTH(12), .MAX_BURST(8), .TIMEOUT_CYCLES(100)) dut (
    .HCLK(HCLK), .HRESET(HRESET),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
    .req_addr_i(req_addr_i), .req_words_i(req_words_i),
    .PADDR(PADDR), .PWDATA(PWDATA), .PWRITE(PWRITE), .PSEL(PSEL), .PENABLE(PENABLE),
    .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR),
    .eot_i(eot_i),
    .data_o(data_o), .data_valid_o(data_valid_o), .data_ready_i(data_ready_i),
    .done_o(done_o), .err_o(err_o)
  );

  always #5 HCLK = ~HCLK;

  // APB slave + SPI master stand-in: drive at negedge, sample 1ns later.
  always @(negedge HCLK) begin
    if (pend_rd) begin
      rd_count = rd_count + 1;
      pend_rd  = 0;
    end
    PRDATA  = RD_BASE + rd_count;
    PREADY  = slow ? 1'($urandom_range(0, 1)) : 1'b1;
    PSLVERR = (err_fired_n < err_req_n) && PSEL && PENABLE && (PADDR == err_addr);
    eot_i   = 1'b0;
    if (eot_cd > 0) begin
      eot_cd = eot_cd - 1;
      if (eot_cd == 0) eot_i = 1'b1;
    end
    #1;
    cyc = cyc + 1;
    if (PSEL) psel_cnt = psel_cnt + 1;
    if (PENABLE && !prev_sel) prot_err = prot_err + 1;
    if (PSEL && prev_done) prot_err = prot_err + 1;
    if (PENABLE && (PADDR !== prev_addr || PWDATA !== prev_wdata || PWRITE !== prev_write))
      prot_err = prot_err + 1;
    prev_done  = PSEL && PENABLE && PREADY;
    prev_sel   = PSEL;
    prev_addr  = PADDR;
    prev_wdata = PWDATA;
    prev_write = PWRITE;
    if (PSEL && PENABLE && PREADY) begin
      if (log_n < 512) begin
        lg_addr[log_n] = PADDR;
        lg_data[log_n] = PWRITE ? PWDATA : PRDATA;
        lg_wr[log_n]   = PWRITE;
        lg_cyc[log_n]  = cyc;
        log_n = log_n + 1;
      end
      if (!PWRITE) pend_rd = 1;
      if (PSLVERR) err_fired_n = err_fired_n + 1;
      if (PWRITE && PADDR == 12'h000 && PWDATA == 32'h0000_0101 && eot_delay > 0) eot_cd = eot_delay;
    end
    if (data_valid_o && data_ready_i) outq.push_back(data_o);
    if (done_o) done_cnt = done_cnt + 1;
  end

  task automatic tick();
    @(posedge HCLK);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks = checks + 1;
    assert (obs === exp)
    else begin
      errors = errors + 1;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_wr(input int i, input logic [11:0] a, input logic [31:0] d, input string tag);
    check({tag, "_addr"}, {19'b0, lg_wr[i], lg_addr[i]}, {19'b0, 1'b1, a});
    check({tag, "_data"}, lg_data[i], d);
  endtask

  task automatic request(input logic [23:0] a, input logic [15:0] w);
    req_addr_i  = a;
    req_words_i = w;
    req_valid_i = 1'b1;
    tick();
    req_valid_i = 1'b0;
  endtask

  task automatic wait_done(input int d0, input int budget, input string tag);
    for (int i = 0; i < budget && done_cnt <= d0; i++) tick();
    check(tag, 32'(done_cnt > d0), 32'd1);
  endtask

  task automatic wait_valid(input int budget, input string tag);
    for (int i = 0; i < budget && !data_valid_o; i++) tick();
    check(tag, {31'b0, data_valid_o}, 32'd1);
  endtask

  initial begin
    int lb, ob, d0, r0, ln, p0, ok;
    bit found;
    logic [31:0] hold;

    HRESET = 1'b1; req_valid_i = 1'b0; req_addr_i = '0; req_words_i = '0;
    data_ready_i = 1'b1; slow = 0; eot_delay = 0; err_req_n = 0; err_addr = '0;
    repeat (3) tick();
    check("rst_req_ready", {31'b0, req_ready_o}, 32'd1);
    check("rst_apb", {29'b0, PSEL, PENABLE, PWRITE}, 32'd0);
    check("rst_paddr", {20'b0, PADDR}, 32'd0);
    check("rst_pwdata", PWDATA, 32'd0);
    check("rst_stream", {29'b0, data_valid_o, done_o, err_o}, 32'd0);
    check("rst_data", data_o, 32'd0);
    HRESET = 1'b0;
    tick();

    // single burst: 0x001000, 2 words, eot 50 cycles after the CTRL write
    lb = log_n; ob = outq.size(); d0 = done_cnt; r0 = rd_count;
    eot_delay = 50;
    request(24'h001000, 16'd2);
    found = 0;
    for (int i = 0; i < 300 && !found; i++) begin
      tick();
      if (eot_i) found = 1;
    end
    check("single_eot_seen", {31'b0, found}, 32'd1);
    check("lat_access", {30'b0, PENABLE, data_valid_o}, 32'b10);
    check("lat_paddr", {20'b0, PADDR}, 32'h020);
    tick();
    check("lat_valid", {31'b0, data_valid_o}, 32'd1);
    check("lat_data", data_o, RD_BASE + r0);
    wait_done(d0, 200, "single_done");
    repeat (3) tick();
    check("single_done_once", done_cnt - d0, 32'd1);
    check("single_nlog", log_n - lb, 32'd6);
    check_wr(lb + 0, 12'h008, 32'h0300_0000, "single_cmd");
    check_wr(lb + 1, 12'h00C, 32'h0010_0000, "single_addr");
    check_wr(lb + 2, 12'h010, 32'h0040_1808, "single_len");
    check_wr(lb + 3, 12'h000, 32'h0000_0101, "single_ctrl");
    check("single_rd0", {19'b0, lg_wr[lb + 4], lg_addr[lb + 4]}, 32'h020);
    check("single_rd1", {19'b0, lg_wr[lb + 5], lg_addr[lb + 5]}, 32'h020);
    check("single_nout", outq.size() - ob, 32'd2);
    check("single_w0", outq[ob], RD_BASE + r0);
    check("single_w1", outq[ob + 1], RD_BASE + r0 + 1);
    check("single_err", {31'b0, err_o}, 32'd0);

    // multi-burst with random PREADY: 20 words -> 8, 8, 4
    lb = log_n; ob = outq.size(); d0 = done_cnt; r0 = rd_count;
    slow = 1; eot_delay = 10;
    request(24'h000000, 16'd20);
    wait_done(d0, 3000, "multi_done");
    slow = 0;
    repeat (2) tick();
    check("multi_nlog", log_n - lb, 32'd32);
    check_wr(lb + 1,  12'h00C, 32'h0000_0000, "multi_addr0");
    check_wr(lb + 2,  12'h010, 32'h0100_1808, "multi_len0");
    check_wr(lb + 13, 12'h00C, 32'h0000_2000, "multi_addr1");
    check_wr(lb + 25, 12'h00C, 32'h0000_4000, "multi_addr2");
    check_wr(lb + 26, 12'h010, 32'h0080_1808, "multi_len2");
    check("multi_nout", outq.size() - ob, 32'd20);
    ok = 0;
    for (int i = 0; i < 20 && ob + i < outq.size(); i++)
      if (outq[ob + i] === RD_BASE + r0 + i) ok = ok + 1;
    check("multi_order", ok, 32'd20);

    // backpressure: stall the stream for 30 cycles
    lb = log_n; ob = outq.size(); d0 = done_cnt; r0 = rd_count;
    data_ready_i = 1'b0; eot_delay = 5;
    request(24'h000100, 16'd3);
    wait_valid(200, "bp_valid_seen");
    hold = data_o; ln = log_n;
    repeat (30) tick();
    check("bp_data_stable", data_o, hold);
    check("bp_first_word", hold, RD_BASE + r0);
    check("bp_valid_held", {31'b0, data_valid_o}, 32'd1);
    check("bp_no_read", log_n - ln, 32'd0);
    data_ready_i = 1'b1;
    wait_done(d0, 200, "bp_done");
    check("bp_nout", outq.size() - ob, 32'd3);
    ok = 0;
    for (int i = 0; i < 3 && ob + i < outq.size(); i++)
      if (outq[ob + i] === RD_BASE + r0 + i) ok = ok + 1;
    check("bp_order", ok, 32'd3);

    // reset in the middle of a burst
    data_ready_i = 1'b0; eot_delay = 5;
    request(24'h000200, 16'd8);
    wait_valid(200, "mid_valid_seen");
    HRESET = 1'b1;
    #1;
    check("mid_rst_req_ready", {31'b0, req_ready_o}, 32'd1);
    check("mid_rst_apb", {30'b0, PSEL, PENABLE}, 32'd0);
    check("mid_rst_stream", {29'b0, data_valid_o, done_o, err_o}, 32'd0);
    check("mid_rst_data", data_o, 32'd0);
    tick();
    HRESET = 1'b0; data_ready_i = 1'b1;
    tick();
    check("mid_rst_after", {30'b0, req_ready_o, PSEL}, 32'b10);

    // zero count
    d0 = done_cnt; p0 = psel_cnt;
    request(24'h123456, 16'd0);
    check("zero_done", {30'b0, done_o, req_ready_o}, 32'b10);
    tick();
    check("zero_idle", {30'b0, done_o, req_ready_o}, 32'b01);
    check("zero_no_psel", psel_cnt - p0, 32'd0);
    check("zero_done_once", done_cnt - d0, 32'd1);

    // address wrap, low address bits ignored
    lb = log_n; d0 = done_cnt; eot_delay = 3;
    request(24'hFFFFFB, 16'd16);
    wait_done(d0, 1000, "wrap_done");
    check("wrap_nlog", log_n - lb, 32'd24);
    check_wr(lb + 1,  12'h00C, 32'hFFFF_F800, "wrap_addr0");
    check_wr(lb + 13, 12'h00C, 32'h0000_1800, "wrap_addr1");

    // slave error on the LEN write
    lb = log_n; ob = outq.size(); d0 = done_cnt;
    err_addr = 12'h010; err_req_n = err_req_n + 1; eot_delay = 3;
    request(24'h000400, 16'd4);
    wait_done(d0, 200, "err_done");
    check("err_flag", {31'b0, err_o}, 32'd1);
    check("err_nlog", log_n - lb, 32'd3);
    check("err_last_addr", {20'b0, lg_addr[lb + 2]}, 32'h010);
    check("err_nout", outq.size() - ob, 32'd0);
    d0 = done_cnt;
    request(24'h000400, 16'd1);
    check("err_cleared", {31'b0, err_o}, 32'd0);
    wait_done(d0, 200, "retry_done");
    check("retry_err", {31'b0, err_o}, 32'd0);
    check("retry_nout", outq.size() - ob, 32'd1);

`ifdef SPI_SEQ_TIMEOUT_EN
    // eot never arrives: soft reset write after the watchdog expires
    lb = log_n; d0 = done_cnt; eot_delay = 0;
    request(24'h000000, 16'd1);
    wait_done(d0, 500, "tmo_done");
    check("tmo_err", {31'b0, err_o}, 32'd1);
    check("tmo_nlog", log_n - lb, 32'd5);
    check_wr(lb + 4, 12'h000, 32'h0000_0010, "tmo_swrst");
    check("tmo_delay", 32'((lg_cyc[lb + 4] - lg_cyc[lb + 3]) >= 100 &&
                           (lg_cyc[lb + 4] - lg_cyc[lb + 3]) <= 106), 32'd1);
`endif

    repeat (2) tick();
    check("apb_protocol", prot_err, 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/spi_flash_read_seq.md
Name: spi_flash_read_seq

Overview:
- APB master sequencer sitting directly upstream of the APB SPI master peripheral; drives its APB slave port.
- Converts a single request (flash byte address, word count) into standard SPI flash READ (0x03) transactions.
- Splits the request into bursts that fit the SPI master RX FIFO, waits for end-of-transfer, drains RXFIFO, and emits 32-bit words on a valid/ready stream.

Parameters:
APB_ADDR_WIDTH, 12, width of PADDR; must match the SPI master instance.
MAX_BURST, 8, maximum words per SPI transaction; must be <= SPI master BUFFER_DEPTH (10).
TIMEOUT_CYCLES, 65535, EOT watchdog limit in HCLK cycles; used only with SPI_SEQ_TIMEOUT_EN.

Ports:
HCLK  in  1  clock
HRESET  in  1  asynchronous reset, active-high
req_valid_i  in  1  request valid
req_ready_o  out  1  request accepted (high only in IDLE)
req_addr_i  in  24  flash byte address, word aligned (bits [1:0] ignored, treated as 0)
req_words_i  in  16  number of 32-bit words to read
PADDR  out  APB_ADDR_WIDTH  APB address to SPI master
PWDATA  out  32  APB write data
PWRITE  out  1  APB write strobe
PSEL  out  1  APB select
PENABLE  out  1  APB enable
PRDATA  in  32  APB read data
PREADY  in  1  APB ready
PSLVERR  in  1  APB slave error
eot_i  in  1  end-of-transfer pulse from SPI master (events_o[1])
data_o  out  32  read word
data_valid_o  out  1  read word valid
data_ready_i  in  1  downstream ready
done_o  out  1  one-cycle pulse at request completion
err_o  out  1  sticky error, cleared when the next request is accepted

Behaviour:
- Reset values: all outputs 0, except req_ready_o = 1. FSM = IDLE.
- Register map of the target (decided):
  - STATUS 0x00
  - CMD 0x08
  - ADDR 0x0C
  - LEN 0x10
  - RXFIFO 0x20
- APB master rules:
  - SETUP cycle: PSEL=1, PENABLE=0.
  - ACCESS cycles: PENABLE=1, held until PREADY=1.
  - PADDR, PWDATA and PWRITE are stable across SETUP and ACCESS.
  - PSEL and PENABLE drop to 0 the cycle after completion.
  - Minimum 2 cycles per access; no back-to-back access without an intervening SETUP.
- Accept:
  - In IDLE with req_valid_i=1: latch addr and remaining count, clear err_o.
  - If req_words_i==0: done_o pulses the next cycle, no APB traffic.
- Per burst, with n = min(remaining, MAX_BURST):
  - W_CMD: write CMD = 0x0300_0000.
  - W_ADDR: write ADDR = {addr, 8'h00}.
  - W_LEN: write LEN = {n*32 [15:0], 2'b0, 6'd24, 2'b0, 6'd8}.
  - W_CTRL: write STATUS = 0x0000_0101 (rd bit0, cs0 bit8).
  - WAIT_EOT: wait for eot_i. An eot_i arriving in any other state is ignored.
  - RD_FIFO: APB read of RXFIFO; capture PRDATA into the output register, data_valid_o=1.
  - PUSH: hold data_o/data_valid_o until data_ready_i. The next RXFIFO read does not start while the output register is full.
  - After n words:
    - addr += 4*n, wrapping modulo 2^24.
    - remaining -= n.
    - If remaining > 0, go to W_CMD; else go to DONE.
- DONE: done_o=1 for one cycle, then IDLE.
- PSLVERR=1 on any completing access:
  - err_o=1, done_o pulses, return to IDLE.
  - The current burst is abandoned; no further words are emitted.
- Transfer-to-data latency: the first data_valid_o is asserted 2 cycles after eot_i, given PREADY=1 immediately.
- HRESET mid-operation:
  - Immediate return to IDLE, PSEL/PENABLE=0, output word discarded.
  - The SPI master's own state is not touched.

Optional Feature:
- Macro: SPI_SEQ_TIMEOUT_EN.
- Defined:
  - A 16-bit counter runs in WAIT_EOT.
  - When the count reaches TIMEOUT_CYCLES: write STATUS = 0x0000_0010 (swrst), then set err_o=1, pulse done_o, return to IDLE.
- Undefined:
  - The counter is absent; WAIT_EOT waits indefinitely.

Test Plan:
- Single burst: addr=0x001000, words=2, PREADY=1, eot 50 cycles after the CTRL write.
  - Required APB writes: 0x08←0x03000000, 0x0C←0x00100000, 0x10←0x00401808, 0x00←0x00000101.
  - Then 2 RXFIFO reads; 2 words out, then done_o.
- Multi-burst: addr=0x000000, words=20.
  - Bursts of 8, 8, 4 at ADDR 0x00000000, 0x00002000, 0x00004000.
  - LEN of last burst = 0x00801808; 20 words out in order.
- Backpressure and reset:
  - Hold data_ready_i=0 for 30 cycles → no further RXFIFO read issued; data_o stable; no word lost or duplicated.
  - Assert HRESET mid-burst → outputs at reset values; req_ready_o=1.
- Zero count: words=0 → done_o exactly 1 cycle after accept, no PSEL activity. Address wrap: addr=0xFFFFF8, words=16 → second burst ADDR = 0x00001800.
- Error: PSLVERR=1 on the LEN write → err_o=1, done_o pulse, CTRL write never issued. A new request then clears err_o.
- With SPI_SEQ_TIMEOUT_EN and TIMEOUT_CYCLES=100, eot never arrives → STATUS←0x00000010 write issued ~100 cycles after the CTRL write, then err_o=1 and done_o.
